sha256_kw_sequencer: RTL and testbench
======================================

SHA256_KW_SEQUENCER -- requirements
Module: sha256_kw_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, meaning the number of compression rounds per block.
REQ-002 SHALL have parameter WORDS, default 16, meaning the 32-bit words per message block.
REQ-003 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_blk_valid  in  1  512-bit message block offered.
REQ-006 i_blk  in  512  block; word 0 = i_blk[511:480], big-endian word order.
REQ-007 o_blk_ready  out  1  block accepted on an edge where i_blk_valid and o_blk_ready are both high.
REQ-008 o_coef_num  out  7  registered index to the external clocked K-constant ROM (1-cycle read latency).
REQ-009 i_coef_value  in  32  K[o_coef_num] from the ROM, valid one edge after o_coef_num.
REQ-010 o_kw_valid  out  1  o_kw/o_round hold a round term; no backpressure.
REQ-011 o_kw  out  32  W[t] + K[t] mod 2^32.
REQ-012 o_round  out  6  round index t of o_kw.
REQ-013 o_last  out  1  high with o_kw_valid when t = 63.

Function
REQ-014 SHALL implement FSM IDLE -> FILL -> RUN -> IDLE; o_blk_ready = 1 only in IDLE and only while i_rst is low.
REQ-015 Acceptance edge E0 SHALL load window w[0..15] = W[0..15], set o_coef_num = 0, and enter FILL.
REQ-016 o_coef_num SHALL increment by 1 on each edge E1..E63 (values 1..63), then return to 0 at E64 and hold 0 until the next acceptance.
REQ-017 FILL SHALL last exactly one cycle; E1 SHALL enter RUN with round counter t = 0.
REQ-018 In RUN, on edge E(t+2), t = 0..63: o_kw <= w[0] + i_coef_value; o_round <= t; o_kw_valid <= 1; o_last <= (t == 63).
REQ-019 On the same edge the window SHALL shift: w[i] <= w[i+1], w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], all mod 2^32.
REQ-020 σ0(x) = ror7 ^ ror18 ^ shr3; σ1(x) = ror17 ^ ror19 ^ shr10.
REQ-021 E65 (t = 63) SHALL return to IDLE; o_kw_valid SHALL fall at the first edge after E65 unless a new output is loaded.
REQ-022 Latency: first o_kw_valid is visible in the cycle after E2, and exactly 64 consecutive valid cycles follow.
REQ-023 Throughput: one block per 66 cycles minimum (acceptance possible in the cycle after E65).
REQ-024 i_blk_valid while not in IDLE SHALL be ignored and not accepted.
REQ-025 o_round SHALL never wrap inside a block; the window is discarded after t = 63.

Reset
REQ-026 i_rst high SHALL force at the next edge: state IDLE, o_coef_num 0, o_kw 0, o_round 0, o_kw_valid 0, o_last 0, and window 0.
REQ-027 Reset mid-block SHALL abort the block; no further o_kw_valid until a new acceptance.
REQ-028 Reset SHALL take priority over acceptance on the same edge.

Structure
REQ-029 Package sha256_pkg SHALL hold the ROUNDS/WORDS constants, the 32-bit word typedef, and the σ0/σ1 functions.
REQ-030 One sub-module, sha256_w_expand, SHALL be combinational: w[0], w[1], w[9], w[14] -> next W.
REQ-031 The K ROM SHALL stay external; the bench instantiates it alongside this block.

Verification
REQ-032 Feed the "abc" padded block (W0 = 0x61626380, W15 = 0x00000018, others 0) -> round 0 o_kw = 0xA3EC9318.
REQ-033 Same block -> round 15 o_kw = 0xC19BF18C, round 16 o_kw = 0x45FDCD41, round 17 o_kw = 0xEFCD4786.
REQ-034 Accept at E0 -> o_kw_valid high for exactly 64 cycles starting after E2; o_last only with o_round = 63; o_coef_num sequence 0..63, then 0.
REQ-035 Pulse i_rst at round 30 -> o_kw_valid low next cycle, o_blk_ready high after reset release, and a new block restarts at round 0 with correct values.
REQ-036 Hold i_blk_valid high continuously with two blocks -> second acceptance occurs in the cycle after E65 of block 1, with no overlap of valid rounds.
REQ-037 Run 100 random blocks against a software SHA-256 schedule model -> all 6400 o_kw values match.

Source files
------------

// File: rtl/sha256_pkg.sv
// ============================================================================
// Module   : sha256_pkg
// Brief    : Shared SHA-256 schedule constants, word type, FSM states and the
//            small-sigma functions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int c_ROUNDS = 64;
    localparam int c_WORDS  = 16;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_w_expand.sv
// ============================================================================
// Module   : sha256_w_expand
// Brief    : Combinational message-schedule step producing the next W word
//            from the sliding window taps w[0], w[1], w[9], w[14].
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_w_expand
    import sha256_pkg::*;
(
    input  word_t i_w0,
    input  word_t i_w1,
    input  word_t i_w9,
    input  word_t i_w14,
    output word_t o_w_next
);

    assign o_w_next = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;

endmodule

`default_nettype wire

// File: rtl/sha256_kw_sequencer.sv
// ============================================================================
// Module   : sha256_kw_sequencer
// Brief    : Accepts a 512-bit block and streams W[t] + K[t] for t = 0..63,
//            prefetching K from an external clocked ROM one round ahead.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_kw_sequencer
    import sha256_pkg::*;
#(
    parameter int ROUNDS = c_ROUNDS,
    parameter int WORDS  = c_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_blk_valid,
    input  logic [WORDS*32-1:0]   i_blk,
    output logic                  o_blk_ready,
    output logic [6:0]            o_coef_num,
    input  logic [31:0]           i_coef_value,
    output logic                  o_kw_valid,
    output logic [31:0]           o_kw,
    output logic [5:0]            o_round,
    output logic                  o_last
);

    localparam logic [5:0] c_LAST_ROUND    = 6'(ROUNDS - 1);
    // ROM address runs two rounds ahead, so it stops counting at t = ROUNDS-3.
    localparam logic [5:0] c_LAST_PREFETCH = 6'(ROUNDS - 3);

    state_t      r_state_q,     w_state_d;
    logic [6:0]  r_coef_num_q,  w_coef_num_d;
    logic [5:0]  r_t_q,         w_t_d;
    word_t       r_win_q [WORDS];
    word_t       w_win_d [WORDS];
    word_t       r_kw_q,        w_kw_d;
    logic [5:0]  r_round_q,     w_round_d;
    logic        r_kw_valid_q,  w_kw_valid_d;
    logic        r_last_q,      w_last_d;
    word_t       w_w_next;

    sha256_w_expand u_w_expand (
        .i_w0     (r_win_q[0]),
        .i_w1     (r_win_q[1]),
        .i_w9     (r_win_q[9]),
        .i_w14    (r_win_q[14]),
        .o_w_next (w_w_next)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_coef_num_d = r_coef_num_q;
        w_t_d        = r_t_q;
        w_win_d      = r_win_q;
        w_kw_d       = r_kw_q;
        w_round_d    = r_round_q;
        w_kw_valid_d = 1'b0;
        w_last_d     = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (i_blk_valid) begin
                    for (int i = 0; i < WORDS; i++) begin
                        w_win_d[i] = i_blk[(WORDS-1-i)*32 +: 32];
                    end
                    w_coef_num_d = 7'd0;
                    w_state_d    = S_FILL;
                end
            end
            S_FILL: begin
                w_coef_num_d = r_coef_num_q + 7'd1;
                w_t_d        = 6'd0;
                w_state_d    = S_RUN;
            end
            S_RUN: begin
                w_kw_d       = r_win_q[0] + i_coef_value;
                w_round_d    = r_t_q;
                w_kw_valid_d = 1'b1;
                w_last_d     = (r_t_q == c_LAST_ROUND);
                for (int i = 0; i < WORDS-1; i++) begin
                    w_win_d[i] = r_win_q[i+1];
                end
                w_win_d[WORDS-1] = w_w_next;
                w_coef_num_d = (r_t_q <= c_LAST_PREFETCH) ? r_coef_num_q + 7'd1 : 7'd0;
                if (r_t_q == c_LAST_ROUND) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_t_d = r_t_q + 6'd1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= S_IDLE;
            r_coef_num_q <= 7'd0;
            r_t_q        <= 6'd0;
            r_kw_q       <= '0;
            r_round_q    <= 6'd0;
            r_kw_valid_q <= 1'b0;
            r_last_q     <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                r_win_q[i] <= '0;
            end
        end else begin
            r_state_q    <= w_state_d;
            r_coef_num_q <= w_coef_num_d;
            r_t_q        <= w_t_d;
            r_kw_q       <= w_kw_d;
            r_round_q    <= w_round_d;
            r_kw_valid_q <= w_kw_valid_d;
            r_last_q     <= w_last_d;
            for (int i = 0; i < WORDS; i++) begin
                r_win_q[i] <= w_win_d[i];
            end
        end
    end

    assign o_blk_ready = (r_state_q == S_IDLE) && !i_rst;
    assign o_coef_num  = r_coef_num_q;
    assign o_kw_valid  = r_kw_valid_q;
    assign o_kw        = r_kw_q;
    assign o_round     = r_round_q;
    assign o_last      = r_last_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_kw_sequencer.sv
// ============================================================================
// Module   : tb_sha256_kw_sequencer
// Brief    : Self-checking bench with an external K ROM and a full-schedule
//            SHA-256 reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_kw_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic [511:0] blk;
    logic         blk_ready;
    logic [6:0]   coef_num;
    logic [31:0]  coef_value;
    logic         kw_valid;
    logic [31:0]  kw;
    logic [5:0]   round;
    logic         last;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_k    = 0;

    logic [31:0] exp_kw [64];
    logic [31:0] cap_kw [64];

    logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int          rnd;
        logic [31:0] kw;
    } vec_t;

    vec_t abc_tab [4];

    always #5 clk = ~clk;

    // External K ROM with one-cycle read latency.
    always @(posedge clk) coef_value <= c_K[coef_num[5:0]];

    sha256_kw_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_blk_valid  (blk_valid),
        .i_blk        (blk),
        .o_blk_ready  (blk_ready),
        .o_coef_num   (coef_num),
        .i_coef_value (coef_value),
        .o_kw_valid   (kw_valid),
        .o_kw         (kw),
        .o_round      (round),
        .o_last       (last)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_exp(input logic [511:0] b);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) exp_kw[t] = w[t] + c_K[t];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h", name, cur_k, act, want);
    endtask

    // Caller is positioned just after a falling edge.
    task automatic run_block(input logic [511:0] b, input bit keep_valid,
                             input logic [511:0] next_b, input int abort_k,
                             input bit expect_immediate);
        int waits;
        compute_exp(b);
        blk       = b;
        blk_valid = 1'b1;
        waits     = 0;
        cur_k     = 0;
        while (!blk_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (!blk_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: no acceptance within %0d cycles", waits);
            blk_valid = 1'b0;
            return;
        end
        if (expect_immediate) chk("b2b_accept_wait", waits, 0);
        @(negedge clk);
        if (keep_valid) blk = next_b;
        else blk_valid = 1'b0;
        chk("e0_coef_num", coef_num, 0);
        chk("e0_kw_valid", kw_valid, 0);
        chk("e0_blk_ready", blk_ready, 0);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            cur_k = k;
            chk("coef_num", coef_num, (k <= 63) ? k : 0);
            chk("blk_ready", blk_ready, (k == 65));
            if (k >= 2) begin
                chk("kw_valid", kw_valid, 1);
                chk("round", round, k - 2);
                chk("kw", kw, exp_kw[k-2]);
                chk("last", last, (k == 65));
                cap_kw[k-2] = kw;
            end else begin
                chk("kw_valid_early", kw_valid, 0);
            end
            if (k == abort_k) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_kw_valid", kw_valid, 0);
                chk("abort_coef_num", coef_num, 0);
                chk("abort_kw", kw, 0);
                chk("abort_round", round, 0);
                chk("abort_last", last, 0);
                chk("abort_ready_in_rst", blk_ready, 0);
                rst = 1'b0;
                #1;
                chk("abort_ready_after", blk_ready, 1);
                @(negedge clk);
                chk("abort_stays_idle", kw_valid, 0);
                return;
            end
        end
        if (!keep_valid) begin
            @(negedge clk);
            cur_k = 66;
            chk("kw_valid_fall", kw_valid, 0);
            chk("last_fall", last, 0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] rb;
        logic [511:0] rb2;

        abc_tab[0] = '{rnd: 0,  kw: 32'hA3EC9318};
        abc_tab[1] = '{rnd: 15, kw: 32'hC19BF18C};
        abc_tab[2] = '{rnd: 16, kw: 32'h45FDCD41};
        abc_tab[3] = '{rnd: 17, kw: 32'hEFCD4786};
        abc = {32'h61626380, 448'h0, 32'h00000018};

        rst       = 1'b1;
        blk_valid = 1'b0;
        blk       = '0;
        repeat (3) @(negedge clk);
        chk("rst_kw_valid", kw_valid, 0);
        chk("rst_coef_num", coef_num, 0);
        chk("rst_kw", kw, 0);
        chk("rst_round", round, 0);
        chk("rst_last", last, 0);
        chk("rst_ready", blk_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", blk_ready, 1);
        @(negedge clk);

        run_block(abc, 1'b0, '0, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("abc_vector", cap_kw[abc_tab[i].rnd], abc_tab[i].kw);

        // Reset wins over a simultaneous acceptance.
        rst       = 1'b1;
        blk_valid = 1'b1;
        blk       = abc;
        @(negedge clk);
        rst       = 1'b0;
        blk_valid = 1'b0;
        #1;
        chk("rst_prio_ready", blk_ready, 1);
        @(negedge clk);
        chk("rst_prio_coef", coef_num, 0);
        chk("rst_prio_valid", kw_valid, 0);

        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
        run_block(rb, 1'b0, '0, 32, 1'b0);
        run_block(abc, 1'b0, '0, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("abc_after_abort", cap_kw[abc_tab[i].rnd], abc_tab[i].kw);

        for (int i = 0; i < 16; i++) begin
            rb[32*i +: 32]  = $urandom();
            rb2[32*i +: 32] = $urandom();
        end
        run_block(rb, 1'b1, rb2, 0, 1'b0);
        run_block(rb2, 1'b0, '0, 0, 1'b1);

        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
            run_block(rb, 1'b0, '0, 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
